// File: rtl/prf_free_list_pkg.sv
// Shared type and helper definitions for the physical-register free list.
//   rob_defs       : PRF sizing and the PRF identifier type used across the ROB/rename slice.
//   free_list_defs : free-list depth, pointer format (wrap bit + index) and pointer helpers.
// FL_DEPTH must be a power of two so that index rollover lines up with the wrap bit.

package rob_defs;
  localparam int unsigned PRF_NUM_ENTS  = 64;
  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned PRF_ID_W      = $clog2(PRF_NUM_ENTS);

  typedef logic [PRF_ID_W-1:0] t_prf_id;
endpackage

package free_list_defs;
  import rob_defs::*;

  localparam int unsigned FL_DEPTH = PRF_NUM_ENTS - NUM_ARCH_REGS;
  localparam int unsigned FL_IDX_W = $clog2(FL_DEPTH);
  localparam int unsigned FL_PTR_W = FL_IDX_W + 1;

  typedef struct packed {
    logic                wrap;
    logic [FL_IDX_W-1:0] idx;
  } t_fl_ptr;

  // Advance a pointer by one; index rollover carries into the wrap bit.
  function automatic t_fl_ptr f_incr_flptr(input t_fl_ptr p);
    logic [FL_PTR_W-1:0] v;
    v = {p.wrap, p.idx} + FL_PTR_W'(1);
    return t_fl_ptr'(v);
  endfunction

  function automatic logic f_fl_empty(input t_fl_ptr wr, input t_fl_ptr rd);
    return ({wr.wrap, wr.idx} == {rd.wrap, rd.idx});
  endfunction

  // Occupancy between rd and wr, modulo 2^FL_PTR_W.
  function automatic logic [FL_PTR_W-1:0] f_fl_count(input t_fl_ptr wr, input t_fl_ptr rd);
    return {wr.wrap, wr.idx} - {rd.wrap, rd.idx};
  endfunction
endpackage

// File: rtl/prf_free_list.sv
// Physical-register free list between retire and rename.
// Hands free PRF IDs to rename in order (speculative head) and takes back the
// old PRF IDs reclaimed at retirement (tail). A committed head tracks retirement
// so a retire-time mispredict restores every flushed allocation in one cycle.
// Optional double-free checker: define PRF_FL_DBLFREE_CHK_EN.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   fl_alloc_rn0          rename consumes the presented PRF
//   fl_valid_rn0          a free PRF is presented
//   fl_prf_id_rn0         presented PRF (entry at speculative head)
//   fl_count_rn0          number of speculatively free entries
//   reclaim_prf_rb1       retiring instruction frees its old PRF
//   reclaim_prf_id_rb1    the old PRF being freed
//   br_mispred_rb1        retire-time flush
//   fl_err                sticky double-free flag (0 when checker not built)

module prf_free_list
  import free_list_defs::*;
#(
  parameter int unsigned PRF_NUM_ENTS  = 64,
  parameter int unsigned NUM_ARCH_REGS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fl_alloc_rn0,
  output logic                  fl_valid_rn0,
  output rob_defs::t_prf_id     fl_prf_id_rn0,
  output logic [FL_PTR_W-1:0]   fl_count_rn0,
  input  logic                  reclaim_prf_rb1,
  input  rob_defs::t_prf_id     reclaim_prf_id_rb1,
  input  logic                  br_mispred_rb1,
  output logic                  fl_err
);

  localparam int unsigned DEPTH = PRF_NUM_ENTS - NUM_ARCH_REGS;

  rob_defs::t_prf_id entries [FL_DEPTH];
  t_fl_ptr           wr_ptr;
  t_fl_ptr           spec_rd_ptr;
  t_fl_ptr           cmt_rd_ptr;

  logic    grant;
  t_fl_ptr wr_ptr_nxt;
  t_fl_ptr spec_rd_ptr_nxt;
  t_fl_ptr cmt_rd_ptr_nxt;

  // Presented head comes straight from flops plus the read mux.
  assign fl_valid_rn0  = !f_fl_empty(wr_ptr, spec_rd_ptr);
  assign fl_prf_id_rn0 = entries[spec_rd_ptr.idx];
  assign fl_count_rn0  = f_fl_count(wr_ptr, spec_rd_ptr);

  // Pointer next-state; a flush restores the head to the committed head
  // including any reclaim advancing it in the same cycle.
  always_comb begin
    grant           = fl_alloc_rn0 & fl_valid_rn0 & ~br_mispred_rb1;
    wr_ptr_nxt      = wr_ptr;
    cmt_rd_ptr_nxt  = cmt_rd_ptr;
    spec_rd_ptr_nxt = spec_rd_ptr;
    if (reclaim_prf_rb1) begin
      wr_ptr_nxt     = f_incr_flptr(wr_ptr);
      cmt_rd_ptr_nxt = f_incr_flptr(cmt_rd_ptr);
    end
    if (br_mispred_rb1) begin
      spec_rd_ptr_nxt = cmt_rd_ptr_nxt;
    end else if (grant) begin
      spec_rd_ptr_nxt = f_incr_flptr(spec_rd_ptr);
    end
  end

  // Storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[FL_IDX_W'(i)] <= rob_defs::t_prf_id'(NUM_ARCH_REGS + i);
      end
      wr_ptr      <= '{wrap: 1'b1, idx: '0};
      spec_rd_ptr <= '{wrap: 1'b0, idx: '0};
      cmt_rd_ptr  <= '{wrap: 1'b0, idx: '0};
    end else begin
      if (reclaim_prf_rb1) begin
        entries[wr_ptr.idx] <= reclaim_prf_id_rb1;
      end
      wr_ptr      <= wr_ptr_nxt;
      spec_rd_ptr <= spec_rd_ptr_nxt;
      cmt_rd_ptr  <= cmt_rd_ptr_nxt;

      // An empty-list alloc is only legal while a reclaim is landing or a flush is pending.
      assert (!(fl_alloc_rn0 && !fl_valid_rn0 && !reclaim_prf_rb1 && !br_mispred_rb1))
        else $error("prf_free_list: alloc while empty");
      // wr-cmt is invariant, so "room to push" means an allocation is outstanding.
      assert (!reclaim_prf_rb1 || (f_fl_count(wr_ptr, spec_rd_ptr) < FL_PTR_W'(FL_DEPTH)))
        else $error("prf_free_list: reclaim into full list");
    end
  end

`ifdef PRF_FL_DBLFREE_CHK_EN
  localparam logic [PRF_NUM_ENTS-1:0] MASK_RST = {PRF_NUM_ENTS{1'b1}} << NUM_ARCH_REGS;

  logic [PRF_NUM_ENTS-1:0] free_mask;
  logic [PRF_NUM_ENTS-1:0] free_mask_nxt;
  logic                    dbl_free;
  logic [FL_PTR_W-1:0]     live;
  logic [FL_IDX_W-1:0]     slot;
  rob_defs::t_prf_id       slot_id;

  // Free-mask next state; a flush rebuilds it from the entries between the
  // committed head and the tail, with this cycle's reclaim write applied.
  always_comb begin
    free_mask_nxt = free_mask;
    dbl_free      = 1'b0;
    live          = '0;
    slot          = '0;
    slot_id       = '0;
    if (grant) begin
      free_mask_nxt[fl_prf_id_rn0] = 1'b0;
    end
    if (reclaim_prf_rb1) begin
      dbl_free                          = free_mask[reclaim_prf_id_rb1];
      free_mask_nxt[reclaim_prf_id_rb1] = 1'b1;
    end
    if (br_mispred_rb1) begin
      free_mask_nxt = '0;
      live          = f_fl_count(wr_ptr_nxt, cmt_rd_ptr_nxt);
      for (int unsigned k = 0; k < FL_DEPTH; k++) begin
        slot    = cmt_rd_ptr_nxt.idx + FL_IDX_W'(k);
        slot_id = (reclaim_prf_rb1 && (slot == wr_ptr.idx)) ? reclaim_prf_id_rb1 : entries[slot];
        if (FL_PTR_W'(k) < live) begin
          free_mask_nxt[slot_id] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_mask <= MASK_RST;
      fl_err    <= 1'b0;
    end else begin
      free_mask <= free_mask_nxt;
      if (dbl_free) begin
        fl_err <= 1'b1;
      end
    end
  end
`else
  assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// Directed + constrained-random bench for prf_free_list with a reference
// model of the free / outstanding / architectural PRF sets.
module tb_prf_free_list;
  import free_list_defs::*;
  typedef rob_defs::t_prf_id t_id;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                alloc;
  logic                rec;
  t_id                 rid;
  logic                mis;
  logic                fl_valid_rn0;
  t_id                 fl_prf_id_rn0;
  logic [FL_PTR_W-1:0] fl_count_rn0;
  logic                fl_err;

  always #5 clk = ~clk;

  prf_free_list dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .fl_alloc_rn0       (alloc),
    .fl_valid_rn0       (fl_valid_rn0),
    .fl_prf_id_rn0      (fl_prf_id_rn0),
    .fl_count_rn0       (fl_count_rn0),
    .reclaim_prf_rb1    (rec),
    .reclaim_prf_id_rb1 (rid),
    .br_mispred_rb1     (mis),
    .fl_err             (fl_err)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: F = speculatively free (in order), O = allocated not retired, A = architectural.
  t_id F[$];
  t_id O[$];
  t_id A[$];
  t_id sb_q[$];
  t_id obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    F.delete(); O.delete(); A.delete(); sb_q.delete(); obs_q.delete();
    for (int i = 0; i < 32; i++) A.push_back(t_id'(i));
    for (int i = 32; i < 64; i++) F.push_back(t_id'(i));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; alloc = 1'b0; rec = 1'b0; rid = '0; mis = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(fl_valid_rn0), 32'd1);
    chk("rst_id",    32'(fl_prf_id_rn0), 32'd32);
    chk("rst_count", 32'(fl_count_rn0), 32'd32);
    chk("rst_err",   32'(fl_err), 32'd0);
    reset_n = 1'b1;
  endtask

  // One cycle: check presented state, drive, update model, check the grant.
  task automatic cycle(input logic a, input logic r, input t_id id, input logic m);
    logic g;
    chk("valid", 32'(fl_valid_rn0), 32'(F.size() != 0));
    chk("count", 32'(fl_count_rn0), 32'(F.size()));
    if (F.size() != 0) chk("head", 32'(fl_prf_id_rn0), 32'(F[0]));
    g = a && (F.size() != 0) && !m;
    if (g) begin
      sb_q.push_back(F[0]);
      obs_q.push_back(fl_prf_id_rn0);
    end
    alloc = a; rec = r; rid = id; mis = m;
    if (g) O.push_back(F.pop_front());
    if (r) begin
      A.push_back(O.pop_front());
      for (int k = 0; k < A.size(); k++) begin
        if (A[k] == id) begin
          A.delete(k);
          break;
        end
      end
      F.push_back(id);
    end
    if (m) begin
      while (O.size() != 0) F.push_front(O.pop_back());
    end
    @(negedge clk);
    alloc = 1'b0; rec = 1'b0; mis = 1'b0;
    if (g) chk("grant_id", 32'(obs_q.pop_front()), 32'(sb_q.pop_front()));
  endtask

  initial begin
    reset_n = 1'b0; alloc = 1'b0; rec = 1'b0; rid = '0; mis = 1'b0;

    // Drain the whole list: IDs 32..63 in order, then empty.
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    chk("drain_valid", 32'(fl_valid_rn0), 32'd0);
    chk("drain_count", 32'(fl_count_rn0), 32'd0);

    // Empty + reclaim 7 with alloc high: no grant now, 7 presented next cycle.
    cycle(1'b1, 1'b1, t_id'(7), 1'b0);
    chk("empty_rec_id", 32'(fl_prf_id_rn0), 32'd7);
    chk("empty_rec_count", 32'(fl_count_rn0), 32'd1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("empty_rec_after", 32'(fl_valid_rn0), 32'd0);

    // 5 allocs, retire 2 (reclaim 3 and 4), flush.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, t_id'(3), 1'b0);
    cycle(1'b0, 1'b1, t_id'(4), 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("flush_id", 32'(fl_prf_id_rn0), 32'd34);
    chk("flush_count", 32'(fl_count_rn0), 32'd32);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // 3 allocs, then reclaim + flush in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, t_id'(5), 1'b1);
    chk("rec_flush_id", 32'(fl_prf_id_rn0), 32'd33);
    chk("rec_flush_count", 32'(fl_count_rn0), 32'd32);

    // Random traffic with pointer wrap.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      logic a;
      logic r;
      logic m;
      t_id  id;
      int   hits;
      a  = ($urandom_range(0, 3) != 0) && (F.size() != 0);
      r  = (O.size() != 0) && ($urandom_range(0, 1) == 1);
      id = r ? A[$urandom_range(0, A.size() - 1)] : t_id'(0);
      m  = ($urandom_range(0, 19) == 0);
      if (a && !m) begin
        hits = 0;
        foreach (O[k]) if (O[k] == fl_prf_id_rn0) hits++;
        foreach (A[k]) if (A[k] == fl_prf_id_rn0) hits++;
        chk("dup_id", 32'(hits), 32'd0);
      end
      cycle(a, r, id, m);
    end
    chk("rand_err", 32'(fl_err), 32'd0);

    // Asynchronous reset mid-operation.
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(fl_count_rn0), 32'd32);
    chk("async_rst_id", 32'(fl_prf_id_rn0), 32'd32);
    do_reset();

`ifdef PRF_FL_DBLFREE_CHK_EN
    // Double free of 40, which is still on the free list.
    cycle(1'b1, 1'b0, '0, 1'b0);
    rec = 1'b1; rid = t_id'(40);
    @(negedge clk);
    rec = 1'b0;
    chk("dbl_err_set", 32'(fl_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("dbl_err_sticky", 32'(fl_err), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("dbl_err_clear", 32'(fl_err), 32'd0);
    do_reset();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
